iir_stim_harness: RTL and testbench
===================================

# iir_stim_harness

Synthesizable stimulus/monitor harness for the IIR filter datapath: it sequences a post-reset hold, drives a fixed-count sample stream plus constant filter coefficients into the filter under test, captures the filter's output stream into count/checksum registers, and raises an end-of-run flag once the stream has drained. It combines the clock/reset-sequencing, data-source and data-sink roles in one block on one clock domain, so the same harness serves both simulation and FPGA bring-up.

## Interface
- NB, 12, sample and coefficient width
- N_SAMPLES, 200, number of valid samples issued per run (1..65535)
- RST_HOLD, 4, cycles `rst_n_o` stays low after `reset` release (>=1)
- DRAIN_CYC, 16, idle cycles after last sample before `end_sim` (>=1)
- B0, B1, B2, 12'h0D5, 12'h1AA, 12'h0D5, feed-forward coefficients
- A1, A2, 12'hC33, 12'h1E0, feedback coefficients
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rst_n_o  out  1  active-low reset for the filter under test
- vOut  out  1  source sample valid
- dOut  out  NB  source sample (two's complement)
- b  out  3*NB  {B2,B1,B0}; B0 in bits NB-1:0
- a  out  2*NB  {A2,A1}; A1 in bits NB-1:0
- vIn  in  1  filter output valid
- dIn  in  NB  filter output sample (signed)
- rx_count  out  16  number of accepted sink samples
- rx_sum  out  32  running sum of sign-extended `dIn`, wraps mod 2^32
- rx_last  out  NB  last accepted `dIn`
- end_sim  out  1  run complete, sticky

## Operation
- States: HOLD -> RUN -> DRAIN -> DONE; DONE is terminal until `reset`.
- HOLD: `rst_n_o`=0, `vOut`=0; exits after RST_HOLD rising edges.
- RUN: `rst_n_o`=1; RUN-cycle index k counts from 0; `vOut`=1 unless k mod 8 == 7 (one bubble every 8 cycles). Each valid cycle presents the current pattern value on `dOut`, and the pattern advances. After the N_SAMPLES-th valid, the state moves to DRAIN.
- DRAIN: `vOut`=0 for DRAIN_CYC cycles, then DONE.
- DONE: `end_sim`=1.
- `dOut` holds its last value while `vOut`=0.
- `b` and `a` are constant concatenations of the parameters and are unaffected by reset.
- Sink: on each edge with `vIn`=1, `rx_count`+1 (saturates at 16'hFFFF), `rx_sum` += sign-extended `dIn`, and `rx_last`=`dIn`. The sink is active in every state.

## Timing
- All outputs are registered.
- Reset values: `rst_n_o`=0, `vOut`=0, `dOut`=0, `end_sim`=0, `rx_count`=0, `rx_sum`=0, `rx_last`=0, state=HOLD, pattern reloaded.
- `rst_n_o` rises at the RST_HOLD-th edge after `reset` deasserts. The first `vOut`=1 follows at edge RST_HOLD+1.
- RUN length: N_SAMPLES + floor((N_SAMPLES-1)/7) cycles.
- `end_sim` rises at the DRAIN_CYC-th edge after the last valid sample.
- Reset asserted mid-run: all registers return to their reset values immediately. The run restarts from HOLD with the pattern reloaded.

## Configuration
- STIM_LFSR_EN defined: pattern is a 16-bit Fibonacci LFSR with seed 16'hACE1, feedback = bit15^bit13^bit12^bit10, next = {lfsr[14:0], fb}; `dOut` = lfsr[NB-1:0].
- STIM_LFSR_EN undefined: pattern is a ramp starting at 0 and incrementing by 1 per valid, wrapping mod 2^NB.

## Test plan
- Ramp, NB=12, N_SAMPLES=16, RST_HOLD=4, `vOut`/`dOut` looped back to `vIn`/`dIn` -> `rx_count`=16, `rx_sum`=120, `rx_last`=15, bubbles at RUN cycles 7 and 15, RUN lasts 18 cycles.
- Reset release -> `rst_n_o` low for exactly 4 edges; first `vOut` at edge 5 with `dOut`=0.
- STIM_LFSR_EN -> first two samples are 12'hCE1 and 12'h9C3.
- DRAIN_CYC=16 -> `end_sim` rises 16 edges after the last valid and stays high; `vOut` stays 0 thereafter.
- Negative sink input, `dIn`=12'hFFF twice -> `rx_sum`=32'hFFFFFFFE, `rx_count`=2.
- `reset` pulsed mid-RUN after 5 samples -> all outputs at reset values; the next run starts again with `dOut`=0 and `end_sim`=0.

Source files
------------

// File: rtl/iir_stim_harness_if.sv
// Bundle of the harness-to-filter signals: source stream, constant
// coefficients, the filter's return stream and the sink/status registers.
// The harness side uses the master modport; the filter side uses slave.
interface iir_stim_harness_if #(
    parameter int NB = 12
);
    logic              rst_n_o;
    logic              vOut;
    logic [NB-1:0]     dOut;
    logic [3*NB-1:0]   b;
    logic [2*NB-1:0]   a;
    logic              vIn;
    logic [NB-1:0]     dIn;
    logic [15:0]       rx_count;
    logic [31:0]       rx_sum;
    logic [NB-1:0]     rx_last;
    logic              end_sim;

    modport master (
        output rst_n_o, vOut, dOut, b, a, rx_count, rx_sum, rx_last, end_sim,
        input  vIn, dIn
    );

    modport slave (
        input  rst_n_o, vOut, dOut, b, a, rx_count, rx_sum, rx_last, end_sim,
        output vIn, dIn
    );
endinterface

// File: rtl/iir_stim_harness.sv
// Stimulus/monitor harness for the IIR filter datapath.
// Sequences a post-reset hold for the filter, streams N_SAMPLES pattern
// values with one bubble every 8 cycles, drains, then flags end_sim.
// The sink accumulates count/checksum/last of the filter output in every state.
// Optional macro STIM_LFSR_EN: pattern is a 16-bit Fibonacci LFSR instead of
// a ramp.
module iir_stim_harness #(
    parameter int            NB        = 12,
    parameter int            N_SAMPLES = 200,
    parameter int            RST_HOLD  = 4,
    parameter int            DRAIN_CYC = 16,
    parameter logic [NB-1:0] B0        = 12'h0D5,
    parameter logic [NB-1:0] B1        = 12'h1AA,
    parameter logic [NB-1:0] B2        = 12'h0D5,
    parameter logic [NB-1:0] A1        = 12'hC33,
    parameter logic [NB-1:0] A2        = 12'h1E0
) (
    input logic                 clock,
    input logic                 reset,
    iir_stim_harness_if.master  bus
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

`ifdef STIM_LFSR_EN
    localparam int            PW       = 16;
    localparam logic [PW-1:0] PAT_SEED = 16'hACE1;
`else
    localparam int            PW       = NB;
    localparam logic [PW-1:0] PAT_SEED = '0;
`endif

    localparam logic [NB-1:0] B_COEF [3] = '{B0, B1, B2};
    localparam logic [NB-1:0] A_COEF [2] = '{A1, A2};

    state_t         state_reg;
    logic [31:0]    hold_cnt_reg;
    logic [31:0]    drain_cnt_reg;
    logic [2:0]     phase_reg;
    logic [15:0]    sent_reg;
    logic [PW-1:0]  pat_reg;
    logic [PW-1:0]  pat_next;
    logic           rst_n_reg;
    logic           v_out_reg;
    logic [NB-1:0]  d_out_reg;
    logic           end_sim_reg;
    logic [15:0]    rx_count_reg;
    logic [31:0]    rx_sum_reg;
    logic [NB-1:0]  rx_last_reg;

    // Next pattern value: LFSR step or ramp increment
`ifdef STIM_LFSR_EN
    always_comb begin
        pat_next = {pat_reg[14:0], pat_reg[15] ^ pat_reg[13] ^ pat_reg[12] ^ pat_reg[10]};
    end
`else
    always_comb begin
        pat_next = pat_reg + PW'(1);
    end
`endif

    // Run sequencer: HOLD -> RUN -> DRAIN -> DONE with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_HOLD;
            hold_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            phase_reg     <= '0;
            sent_reg      <= '0;
            pat_reg       <= PAT_SEED;
            rst_n_reg     <= 1'b0;
            v_out_reg     <= 1'b0;
            d_out_reg     <= '0;
            end_sim_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    v_out_reg <= 1'b0;
                    if (hold_cnt_reg == 32'(RST_HOLD - 1)) begin
                        state_reg <= ST_RUN;
                        rst_n_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 32'd1;
                    end
                end
                ST_RUN: begin
                    phase_reg <= phase_reg + 3'd1;
                    if (phase_reg == 3'd7) begin
                        // bubble cycle: dOut keeps its previous sample
                        v_out_reg <= 1'b0;
                    end else begin
                        v_out_reg <= 1'b1;
                        d_out_reg <= pat_reg[NB-1:0];
                        pat_reg   <= pat_next;
                        sent_reg  <= sent_reg + 16'd1;
                        if (sent_reg == 16'(N_SAMPLES - 1)) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    v_out_reg <= 1'b0;
                    if (drain_cnt_reg == 32'(DRAIN_CYC - 1)) begin
                        state_reg   <= ST_DONE;
                        end_sim_reg <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 32'd1;
                    end
                end
                default: begin
                    v_out_reg   <= 1'b0;
                    end_sim_reg <= 1'b1;
                end
            endcase
        end
    end

    // Sink: count (saturating), wrapping signed checksum and last sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_count_reg <= '0;
            rx_sum_reg   <= '0;
            rx_last_reg  <= '0;
        end else if (bus.vIn) begin
            if (rx_count_reg != 16'hFFFF) begin
                rx_count_reg <= rx_count_reg + 16'd1;
            end
            rx_sum_reg  <= rx_sum_reg + {{(32-NB){bus.dIn[NB-1]}}, bus.dIn};
            rx_last_reg <= bus.dIn;
        end
    end

    // Coefficient buses are pure constants, independent of reset
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_b
            assign bus.b[gi*NB +: NB] = B_COEF[gi];
        end
        for (gi = 0; gi < 2; gi++) begin : g_a
            assign bus.a[gi*NB +: NB] = A_COEF[gi];
        end
    endgenerate

    assign bus.rst_n_o  = rst_n_reg;
    assign bus.vOut     = v_out_reg;
    assign bus.dOut     = d_out_reg;
    assign bus.end_sim  = end_sim_reg;
    assign bus.rx_count = rx_count_reg;
    assign bus.rx_sum   = rx_sum_reg;
    assign bus.rx_last  = rx_last_reg;

endmodule

// File: tb/tb_iir_stim_harness.sv
// Testbench for iir_stim_harness: scoreboard of expected source samples
// (value and launch edge) checked by a monitor, plus sink checks in
// loopback, negative-input and random-injection runs.
// Build with STIM_LFSR_EN defined to exercise the LFSR pattern.
module tb_iir_stim_harness;

    localparam int NB        = 12;
    localparam int N_SAMPLES = 16;
    localparam int RST_HOLD  = 4;
    localparam int DRAIN_CYC = 16;
    localparam logic [3*NB-1:0] EXP_B = {12'h0D5, 12'h1AA, 12'h0D5};
    localparam logic [2*NB-1:0] EXP_A = {12'h1E0, 12'hC33};
    // Launch edge of the last sample: RST_HOLD+1 + (N-1) + (N-1)/7
    localparam int LAST_EDGE = RST_HOLD + 1 + (N_SAMPLES - 1) + (N_SAMPLES - 1) / 7;
    localparam int END_EDGE  = LAST_EDGE + DRAIN_CYC;

    typedef struct {
        int            edge_n;
        logic [NB-1:0] data;
    } exp_t;

    logic clock;
    logic reset;
    logic loop_en;
    logic drv_v;
    logic [NB-1:0] drv_d;

    int   vectors;
    int   miscompares;
    int   cyc;
    int   pops;
    exp_t exp_q[$];
    logic [NB-1:0] mon_last_d;

    iir_stim_harness_if #(.NB(NB)) bus ();

    assign bus.vIn = loop_en ? bus.vOut : drv_v;
    assign bus.dIn = loop_en ? bus.dOut : drv_d;

    iir_stim_harness #(
        .NB        (NB),
        .N_SAMPLES (N_SAMPLES),
        .RST_HOLD  (RST_HOLD),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since reset release
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference pattern: i-th issued sample
    function automatic logic [NB-1:0] pat_val(input int i);
`ifdef STIM_LFSR_EN
        logic [15:0] s = 16'hACE1;
        for (int j = 0; j < i; j++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s[NB-1:0];
`else
        logic [31:0] t = i;
        return t[NB-1:0];
`endif
    endfunction

    function automatic logic [31:0] sext(input logic [NB-1:0] d);
        return {{(32-NB){d[NB-1]}}, d};
    endfunction

    task automatic push_run();
        exp_q.delete();
        pops = 0;
        for (int i = 0; i < N_SAMPLES; i++)
            exp_q.push_back('{RST_HOLD + 1 + i + i / 7, pat_val(i)});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".rst_n_o"},  bus.rst_n_o,  0);
        chk({tag, ".vOut"},     bus.vOut,     0);
        chk({tag, ".dOut"},     bus.dOut,     0);
        chk({tag, ".end_sim"},  bus.end_sim,  0);
        chk({tag, ".rx_count"}, bus.rx_count, 0);
        chk({tag, ".rx_sum"},   bus.rx_sum,   0);
        chk({tag, ".rx_last"},  bus.rx_last,  0);
        chk({tag, ".b"},        bus.b,        EXP_B);
        chk({tag, ".a"},        bus.a,        EXP_A);
    endtask

    task automatic step();
        @(posedge clock);
        #3;
    endtask

    // Monitor: per-cycle sequencing checks and scoreboard pop on each valid
    always @(negedge clock) begin
        if (reset) begin
            mon_last_d = '0;
        end else begin
            chk("rst_n_o", bus.rst_n_o, (cyc >= RST_HOLD) ? 1 : 0);
            chk("end_sim", bus.end_sim, (cyc >= END_EDGE) ? 1 : 0);
            if (bus.vOut) begin
                if (exp_q.size() == 0) begin
                    chk("extra_vOut", bus.vOut, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sample_edge", cyc, e.edge_n);
                    chk("sample_data", bus.dOut, e.data);
                    $display("sample %0d at edge %0d dOut=%h", pops, cyc, bus.dOut);
                    pops++;
                end
                mon_last_d = bus.dOut;
            end else begin
                chk("dOut_hold", bus.dOut, mon_last_d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] m_cnt;
        logic [31:0] m_sum;
        logic [NB-1:0] m_last;
        int t;

        vectors = 0; miscompares = 0; pops = 0;
        reset = 1'b1; loop_en = 1'b1; drv_v = 1'b0; drv_d = '0;
        #12;
        check_reset_vals("por");
`ifdef STIM_LFSR_EN
        chk("lfsr_first", pat_val(0), 12'hCE1);
        chk("lfsr_second", pat_val(1), 12'h9C3);
`endif

        // Run 1: loopback, interrupted by reset after 5 samples
        push_run();
        step(); reset = 1'b0;
        t = 0;
        while (pops < 5 && t < 100) begin step(); t++; end
        chk("reach_5_samples", (pops >= 5) ? 1 : 0, 1);
        @(posedge clock); #2 reset = 1'b1;
        #1 check_reset_vals("midrun");

        // Run 2: full loopback run from a fresh start
        push_run();
        step(); reset = 1'b0;
        t = 0;
        while (!bus.end_sim && t < 200) begin step(); t++; end
        chk("end_sim_reached", bus.end_sim, 1);
        m_sum = '0;
        for (int i = 0; i < N_SAMPLES; i++) m_sum += sext(pat_val(i));
        chk("lb_rx_count", bus.rx_count, N_SAMPLES);
        chk("lb_rx_sum",   bus.rx_sum,   m_sum);
        chk("lb_rx_last",  bus.rx_last,  pat_val(N_SAMPLES - 1));
        for (int i = 0; i < 10; i++) step();
        chk("lb_queue_empty", exp_q.size(), 0);
        chk("lb_rx_count_stable", bus.rx_count, N_SAMPLES);

        // Run 3: sink driven by the bench: two -1 samples, then random traffic
        loop_en = 1'b0;
        @(posedge clock); #2 reset = 1'b1;
        #1 check_reset_vals("run3");
        push_run();
        step(); reset = 1'b0;
        m_cnt = '0; m_sum = '0; m_last = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            drv_v = 1'b1; drv_d = '1;
            m_cnt++; m_sum += sext(drv_d); m_last = drv_d;
        end
        step();
        drv_v = 1'b0;
        chk("neg_rx_sum",   bus.rx_sum,   32'hFFFF_FFFE);
        chk("neg_rx_count", bus.rx_count, 2);
        chk("neg_rx_last",  bus.rx_last,  12'hFFF);
        t = 0;
        while (t < 200) begin
            step(); t++;
            if (bus.end_sim) break;
            drv_v = 1'($urandom_range(0, 1));
            drv_d = NB'($urandom);
            if (drv_v) begin
                m_cnt++; m_sum += sext(drv_d); m_last = drv_d;
            end
        end
        drv_v = 1'b0;
        chk("rnd_end_sim", bus.end_sim, 1);
        chk("rnd_rx_count", bus.rx_count, m_cnt);
        chk("rnd_rx_sum",   bus.rx_sum,   m_sum);
        chk("rnd_rx_last",  bus.rx_last,  m_last);
        step(); step();
        chk("rnd_queue_empty", exp_q.size(), 0);
        chk("b_const", bus.b, EXP_B);
        chk("a_const", bus.a, EXP_A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
